// File: rtl/eth_tx_arb_pkg.sv
// Shared types and widths for the Ethernet TX frame arbiter.
package eth_tx_arb_pkg;
  localparam int STATE_W = 2;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 11;
  localparam int STAT_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_t;
endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin selector: first requester above ptr_i, wrapping mod N_REQ.
module eth_rr_pick
  import eth_tx_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);
  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0]     ptr_plus;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate so bit 0 is the requester just after the pointer; ptr+1 <= N_REQ keeps it in range.
  assign ptr_plus = {1'b0, ptr_i} + (IDX_W+1)'(1);
  assign dbl      = {req_i, req_i} >> ptr_plus;
  assign rot      = dbl[N_REQ-1:0];

  always_comb begin
    off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
  end

  assign sum     = ptr_plus + {1'b0, off};
  assign idx_o   = (sum >= N_L) ? IDX_W'(sum - N_L) : IDX_W'(sum);
  assign found_o = |req_i;
endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the MAC TX byte path, with IFG hold-off and
// runaway-frame truncation. Define ETH_TX_ARB_STATS_EN to add frame_cnt / trunc_cnt statistics.
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int IFG_CYCLES = 48,
  parameter int MAX_BYTES  = 1514
) (
  input  logic                   clk_mac,
  input  logic                   rst,
  input  logic [8*N_REQ-1:0]     s_tdata,
  input  logic [N_REQ-1:0]       s_tvalid,
  input  logic [N_REQ-1:0]       s_tlast,
  output logic [N_REQ-1:0]       s_tready,
  output logic [7:0]             m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   trunc_pulse
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [STAT_W*N_REQ-1:0] frame_cnt,
  output logic [STAT_W-1:0]       trunc_cnt
`endif
);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BYTES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, ptr_q, ptr_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [N_REQ-1:0] grant_oh;
  logic [7:0]       g_data;
  logic             g_valid, g_last, forced_last, pick_found;
  logic [IDX_W-1:0] pick_idx;

  eth_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i  (s_tvalid),
    .ptr_i  (ptr_q),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_oh
    assign grant_oh[gi] = (grant_q == IDX_W'(gi));
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N_REQ; i++) g_data |= s_tdata[8*i +: 8] & {8{grant_oh[i]}};
  end

  assign g_valid     = |(s_tvalid & grant_oh);
  assign g_last      = |(s_tlast & grant_oh);
  assign forced_last = (beat_q == BEAT_LAST);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tdata     = '0;
    s_tready    = '0;
    trunc_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          ptr_d   = pick_idx;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        m_tvalid = g_valid;
        m_tdata  = g_data;
        m_tlast  = g_last | forced_last;
        s_tready = grant_oh & {N_REQ{m_tready}};
        if (g_valid && m_tready) begin
          if (beat_q != '1) beat_d = beat_q + 1'b1;
          if (g_last) begin
            state_d = GAP;
          end else if (forced_last) begin
            state_d     = DRAIN;
            trunc_pulse = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Swallow the rest of the runaway frame so the source can reach its tlast.
        s_tready = grant_oh;
        if (g_valid && g_last) state_d = GAP;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_mac or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      beat_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_idx = grant_q;

`ifdef ETH_TX_ARB_STATS_EN
  logic              frame_done;
  logic [STAT_W-1:0] trunc_cnt_q;

  assign frame_done = (state_q == XFER) && g_valid && m_tready && (g_last || forced_last);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fcnt
    logic [STAT_W-1:0] fcnt_q;
    always_ff @(posedge clk_mac or posedge rst) begin
      if (rst)                             fcnt_q <= '0;
      else if (frame_done && grant_oh[gi]) fcnt_q <= fcnt_q + 1'b1;
    end
    assign frame_cnt[STAT_W*gi +: STAT_W] = fcnt_q;
  end

  always_ff @(posedge clk_mac or posedge rst) begin
    if (rst)                                   trunc_cnt_q <= '0;
    else if (trunc_pulse && trunc_cnt_q != '1) trunc_cnt_q <= trunc_cnt_q + 1'b1;
  end
  assign trunc_cnt = trunc_cnt_q;
`endif
endmodule
